// File: rtl/ofdm_interleaver.sv
// 802.11a transmit block interleaver: bit-serial in, ping-pong banks, bit-serial out in interleaved order.
// The write address is formed from the input index counters without any divider.
module ofdm_interleaver #(
  parameter int NCBPS_MAX = 288,
  parameter int ADDR_W    = 9
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       x,
  input  logic [3:0] Rate,
  output logic       y,
  output logic       Valid,
  output logic       SymEnd
);

  localparam logic [1:0] MODE_48  = 2'd0;
  localparam logic [1:0] MODE_96  = 2'd1;
  localparam logic [1:0] MODE_192 = 2'd2;
  localparam logic [1:0] MODE_288 = 2'd3;

  function automatic logic [1:0] rate_mode(input logic [3:0] r);
    case (r)
      4'b1101, 4'b1111: rate_mode = MODE_48;
      4'b0101, 4'b0111: rate_mode = MODE_96;
      4'b1001, 4'b1011: rate_mode = MODE_192;
      4'b0001, 4'b0011: rate_mode = MODE_288;
      default:          rate_mode = MODE_48;
    endcase
  endfunction

  // Remainder modulo 3 by shift-and-subtract over the bits.
  function automatic logic [1:0] mod3(input logic [4:0] v);
    logic [2:0] acc;
    acc = 3'd0;
    for (int b = 4; b >= 0; b--) begin
      acc = {acc[1:0], v[b]};
      if (acc >= 3'd3) acc = acc - 3'd3;
    end
    return acc[1:0];
  endfunction

  // Write side state: k = 16*k_hi + k_lo.
  logic [3:0]        k_lo;
  logic [4:0]        k_hi;
  logic              wr_sel;
  logic [1:0]        wr_mode;
  logic [1:0]        cur_mode;
  logic              first_bit;
  logic              last_bit;
  logic [4:0]        cols;
  logic [4:0]        cols_m1;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] i_idx;
  logic [ADDR_W-1:0] j_idx;
  logic [1:0]        r_hi;
  logic [1:0]        r_lo;
  logic [2:0]        diff;
  logic [1:0]        rot;

  // Read side state.
  logic [1:0]                 full;
  logic [1:0][ADDR_W-1:0]     bank_last;
  logic                       rd_sel;
  logic [ADDR_W-1:0]          rd_addr;
  logic                       rd_bit;
  logic                       rd_last;

  logic mem0 [NCBPS_MAX];
  logic mem1 [NCBPS_MAX];

  assign first_bit = (k_lo == 4'd0) && (k_hi == 5'd0);
  // Rate is only honoured on the first bit of a symbol; afterwards the latched mode holds.
  assign cur_mode  = first_bit ? rate_mode(Rate) : wr_mode;

  always_comb begin
    cols      = 5'd3;
    cols_m1   = 5'd2;
    last_addr = ADDR_W'(47);
    case (cur_mode)
      MODE_48:  begin cols = 5'd3;  cols_m1 = 5'd2;  last_addr = ADDR_W'(47);  end
      MODE_96:  begin cols = 5'd6;  cols_m1 = 5'd5;  last_addr = ADDR_W'(95);  end
      MODE_192: begin cols = 5'd12; cols_m1 = 5'd11; last_addr = ADDR_W'(191); end
      MODE_288: begin cols = 5'd18; cols_m1 = 5'd17; last_addr = ADDR_W'(287); end
      default:  begin cols = 5'd3;  cols_m1 = 5'd2;  last_addr = ADDR_W'(47);  end
    endcase
  end

  assign last_bit = (k_lo == 4'd15) && (k_hi == cols_m1);

  // First step. Because k_hi < cols, floor(16*i/NCBPS) is simply k_lo, and NCBPS is
  // a multiple of s in every mode, so the second step reduces to ((i - k_lo) mod s).
  assign i_idx = ADDR_W'(cols) * ADDR_W'(k_lo) + ADDR_W'(k_hi);

  always_comb begin
    j_idx = i_idx;
    r_hi  = 2'd0;
    r_lo  = 2'd0;
    diff  = 3'd0;
    rot   = 2'd0;
    case (cur_mode)
      MODE_48: j_idx = i_idx;
      MODE_96: j_idx = i_idx;
      MODE_192: j_idx = {i_idx[ADDR_W-1:1], i_idx[0] ^ k_lo[0]};
      MODE_288: begin
        // cols = 18 is a multiple of 3, so i mod 3 equals k_hi mod 3.
        r_hi  = mod3(k_hi);
        r_lo  = mod3({1'b0, k_lo});
        diff  = {1'b0, r_hi} + 3'd3 - {1'b0, r_lo};
        rot   = (diff >= 3'd3) ? 2'(diff - 3'd3) : diff[1:0];
        j_idx = i_idx - ADDR_W'(r_hi) + ADDR_W'(rot);
      end
      default: j_idx = i_idx;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      k_lo    <= 4'd0;
      k_hi    <= 5'd0;
      wr_sel  <= 1'b0;
      wr_mode <= MODE_48;
    end else if (Start) begin
      wr_mode <= cur_mode;
      if (last_bit) begin
        k_lo   <= 4'd0;
        k_hi   <= 5'd0;
        wr_sel <= ~wr_sel;
      end else begin
        k_lo <= k_lo + 4'd1;
        if (k_lo == 4'd15) k_hi <= k_hi + 5'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Start) begin
      if (wr_sel) mem1[j_idx] <= x;
      else        mem0[j_idx] <= x;
    end
  end

  assign rd_bit  = rd_sel ? mem1[rd_addr] : mem0[rd_addr];
  assign rd_last = (rd_addr == bank_last[rd_sel]);

  // A bank filled on edge E is seen full on E+1; the set below follows the clear so that a
  // simultaneous final read of one bank and final write of the other never loses a flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      full      <= 2'b00;
      bank_last <= '0;
      rd_sel    <= 1'b0;
      rd_addr   <= '0;
      y         <= 1'b0;
      Valid     <= 1'b0;
      SymEnd    <= 1'b0;
    end else begin
      if (full[rd_sel]) begin
        y      <= rd_bit;
        Valid  <= 1'b1;
        SymEnd <= rd_last;
        if (rd_last) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
          rd_addr      <= '0;
        end else begin
          rd_addr <= rd_addr + ADDR_W'(1);
        end
      end else begin
        y      <= 1'b0;
        Valid  <= 1'b0;
        SymEnd <= 1'b0;
      end
      if (Start && last_bit) begin
        full[wr_sel]      <= 1'b1;
        bank_last[wr_sel] <= last_addr;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_interleaver.sv
// Directed bench for ofdm_interleaver: one-hot permutation points, rate coverage,
// back-to-back streaming, Start gaps, rate hold, mid-symbol reset and loopback recovery.
module tb_ofdm_interleaver;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       x;
  logic [3:0] Rate;
  logic       y;
  logic       Valid;
  logic       SymEnd;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int first_bit_edge = 0;
  bit mon_en = 1'b0;

  logic [0:0] exp_q[$];
  logic       in_q[$];
  logic       out_q[$];
  logic       end_q[$];
  int         vedge_q[$];
  logic       ref_q[$];

  ofdm_interleaver #(.NCBPS_MAX(288), .ADDR_W(9)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .x(x), .Rate(Rate),
    .y(y), .Valid(Valid), .SymEnd(SymEnd)
  );

  // Clock and edge counter
  always #5 Clk = ~Clk;
  always @(posedge Clk) edge_cnt++;

  // Output monitor, sampled on the falling edge
  always @(negedge Clk) begin
    if (mon_en && Valid) begin
      out_q.push_back(y);
      end_q.push_back(SymEnd);
      vedge_q.push_back(edge_cnt);
    end
  end

  function automatic int tb_n(input logic [3:0] r);
    case (r)
      4'b0101, 4'b0111: return 96;
      4'b1001, 4'b1011: return 192;
      4'b0001, 4'b0011: return 288;
      default:          return 48;
    endcase
  endfunction

  function automatic int tb_bpsc(input logic [3:0] r);
    case (r)
      4'b0101, 4'b0111: return 2;
      4'b1001, 4'b1011: return 4;
      4'b0001, 4'b0011: return 6;
      default:          return 1;
    endcase
  endfunction

  function automatic int perm(input int k, input int n, input int bpsc);
    int s;
    int i;
    s = (bpsc / 2 > 1) ? bpsc / 2 : 1;
    i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  task automatic clear_mon();
    out_q.delete();
    end_q.delete();
    vedge_q.delete();
    exp_q.delete();
  endtask

  task automatic build_exp(input int n, input int bpsc);
    logic sym [288];
    for (int base = 0; base + n <= in_q.size(); base += n) begin
      for (int k = 0; k < n; k++) sym[perm(k, n, bpsc)] = in_q[base + k];
      for (int jj = 0; jj < n; jj++) exp_q.push_back(sym[jj]);
    end
  endtask

  // Drives in_q; gaps inserts one idle cycle after every bit; chg_at switches Rate before that bit.
  task automatic drive_bits(input bit gaps, input int chg_at, input logic [3:0] chg_rate);
    for (int i = 0; i < in_q.size(); i++) begin
      @(posedge Clk); #1;
      if (i == chg_at) Rate = chg_rate;
      if (i == 0) first_bit_edge = edge_cnt + 1;
      Start = 1'b1;
      x = in_q[i];
      if (gaps) begin
        @(posedge Clk); #1;
        Start = 1'b0;
      end
    end
    @(posedge Clk); #1;
    Start = 1'b0;
    x = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int c = 0; c < 3000 && out_q.size() < n; c++) @(posedge Clk);
    repeat (6) @(posedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b0; x = 1'b0; Rate = 4'b1101;
    #1;
    checks++;
    if ({y, Valid, SymEnd} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got y/Valid/SymEnd=%b required 000", {y, Valid, SymEnd});
    end
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (Valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got Valid=%b required 0", Valid);
    end
    mon_en = 1'b1;
  endtask

  // One-hot input at k, hand-computed output index idx.
  task automatic test_onehot(input logic [3:0] r, input int n, input int k, input int idx);
    clear_mon();
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back(i == k);
    Rate = r;
    drive_bits(1'b0, -1, 4'b0000);
    wait_out(n);
    checks++;
    if (out_q.size() != n) begin
      errors++;
      $display("FAIL onehot_count rate=%b: got %0d outputs required %0d", r, out_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      logic got;
      got = (i < out_q.size()) ? out_q[i] : 1'bx;
      checks++;
      if (got !== (i == idx)) begin
        errors++;
        $display("FAIL onehot rate=%b k=%0d idx=%0d: got %b required %b", r, k, i, got, (i == idx));
      end
    end
    // Counting the accepting edge as edge 1, Valid first appears after edge NCBPS+1.
    checks++;
    if (vedge_q.size() == 0 || vedge_q[0] - first_bit_edge != n) begin
      errors++;
      $display("FAIL onehot_latency rate=%b: got %0d required %0d", r,
               (vedge_q.size() == 0) ? -1 : vedge_q[0] - first_bit_edge, n);
    end
    checks++;
    if (end_q.size() != n || end_q[n-1] !== 1'b1 || end_q[0] !== 1'b0) begin
      errors++;
      $display("FAIL onehot_symend rate=%b: got size %0d required SymEnd only at %0d", r, end_q.size(), n - 1);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    in_q.delete();
    for (int i = 0; i < 480; i++) in_q.push_back(1'($urandom_range(0, 1)));
    Rate = 4'b1101;
    build_exp(48, 1);
    drive_bits(1'b0, -1, 4'b0000);
    wait_out(480);
    checks++;
    if (out_q.size() != 480) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 480", out_q.size());
    end
    for (int i = 0; i < 480; i++) begin
      logic got;
      logic ge;
      got = (i < out_q.size()) ? out_q[i] : 1'bx;
      ge  = (i < end_q.size()) ? end_q[i] : 1'bx;
      checks++;
      if (got !== exp_q[i][0]) begin
        errors++;
        $display("FAIL b2b_data idx=%0d: got %b required %b", i, got, exp_q[i][0]);
      end
      checks++;
      if (ge !== (i % 48 == 47)) begin
        errors++;
        $display("FAIL b2b_symend idx=%0d: got %b required %b", i, ge, (i % 48 == 47));
      end
    end
    checks++;
    if (vedge_q.size() != 480 || vedge_q[479] - vedge_q[0] != 479) begin
      errors++;
      $display("FAIL b2b_continuous: got span %0d required 479",
               (vedge_q.size() == 480) ? vedge_q[479] - vedge_q[0] : -1);
    end
  endtask

  task automatic test_start_gaps();
    clear_mon();
    in_q.delete();
    for (int i = 0; i < 192; i++) in_q.push_back(1'($urandom_range(0, 1)));
    Rate = 4'b0101;
    drive_bits(1'b0, -1, 4'b0000);
    wait_out(192);
    ref_q = out_q;
    clear_mon();
    build_exp(96, 2);
    drive_bits(1'b1, -1, 4'b0000);
    wait_out(192);
    checks++;
    if (out_q.size() != 192 || ref_q.size() != 192) begin
      errors++;
      $display("FAIL gaps_count: got %0d/%0d required 192", out_q.size(), ref_q.size());
    end
    for (int i = 0; i < 192; i++) begin
      logic got;
      logic rf;
      got = (i < out_q.size()) ? out_q[i] : 1'bx;
      rf  = (i < ref_q.size()) ? ref_q[i] : 1'bx;
      checks++;
      if (got !== exp_q[i][0] || rf !== exp_q[i][0]) begin
        errors++;
        $display("FAIL gaps_data idx=%0d: got gapped=%b continuous=%b required %b", i, got, rf, exp_q[i][0]);
      end
    end
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (vedge_q.size() != 192 || vedge_q[96*s+95] - vedge_q[96*s] != 95) begin
        errors++;
        $display("FAIL gaps_readout sym=%0d: got span %0d required 95", s,
                 (vedge_q.size() == 192) ? vedge_q[96*s+95] - vedge_q[96*s] : -1);
      end
    end
  endtask

  task automatic test_rate_hold();
    clear_mon();
    in_q.delete();
    for (int i = 0; i < 96; i++) in_q.push_back(1'($urandom_range(0, 1)));
    Rate = 4'b0101;
    build_exp(96, 2);
    drive_bits(1'b0, 50, 4'b1101);
    Rate = 4'b0101;
    wait_out(96);
    checks++;
    if (out_q.size() != 96) begin
      errors++;
      $display("FAIL rate_hold_count: got %0d required 96", out_q.size());
    end
    for (int i = 0; i < 96; i++) begin
      logic got;
      got = (i < out_q.size()) ? out_q[i] : 1'bx;
      checks++;
      if (got !== exp_q[i][0]) begin
        errors++;
        $display("FAIL rate_hold_data idx=%0d: got %b required %b", i, got, exp_q[i][0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_mon();
    in_q.delete();
    for (int i = 0; i < 48; i++) in_q.push_back(1'b1);
    for (int i = 0; i < 30; i++) in_q.push_back(1'b0);
    Rate = 4'b1101;
    drive_bits(1'b0, -1, 4'b0000);
    checks++;
    if (Valid !== 1'b1 || y !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre: got Valid=%b y=%b required 1 1", Valid, y);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({y, Valid, SymEnd} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got y/Valid/SymEnd=%b required 000", {y, Valid, SymEnd});
    end
    @(posedge Clk); #1 Reset = 1'b1;
    repeat (4) @(posedge Clk);
    clear_mon();
    in_q.delete();
    for (int i = 0; i < 48; i++) in_q.push_back(1'($urandom_range(0, 1)));
    build_exp(48, 1);
    drive_bits(1'b0, -1, 4'b0000);
    wait_out(48);
    checks++;
    if (out_q.size() != 48) begin
      errors++;
      $display("FAIL post_reset_count: got %0d required 48", out_q.size());
    end
    for (int i = 0; i < 48; i++) begin
      logic got;
      got = (i < out_q.size()) ? out_q[i] : 1'bx;
      checks++;
      if (got !== exp_q[i][0]) begin
        errors++;
        $display("FAIL post_reset_data idx=%0d: got %b required %b", i, got, exp_q[i][0]);
      end
    end
  endtask

  task automatic test_loopback();
    clear_mon();
    in_q.delete();
    for (int i = 0; i < 480; i++) in_q.push_back(1'($urandom_range(0, 1)));
    Rate = 4'b1101;
    drive_bits(1'b0, -1, 4'b0000);
    wait_out(480);
    for (int base = 0; base < 480; base += 48) begin
      for (int k = 0; k < 48; k++) begin
        int   idx;
        logic rec;
        idx = base + perm(k, tb_n(Rate), tb_bpsc(Rate));
        rec = (idx < out_q.size()) ? out_q[idx] : 1'bx;
        checks++;
        if (rec !== in_q[base + k]) begin
          errors++;
          $display("FAIL loopback bit=%0d: got %b required %b", base + k, rec, in_q[base + k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_onehot(4'b1101, 48, 1, 3);
    test_onehot(4'b1101, 48, 16, 1);
    test_onehot(4'b1001, 192, 1, 13);
    test_onehot(4'b0001, 288, 1, 20);
    test_onehot(4'b0011, 288, 17, 18);
    test_onehot(4'b0111, 96, 16, 1);
    test_onehot(4'b0000, 48, 1, 3);
    test_back_to_back();
    test_start_gaps();
    test_rate_hold();
    test_mid_reset();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
